// File: rtl/ysyx_22040127_pkg.sv
// Shared definitions for the core's memory-side blocks: responder FSM states
// and the physical memory base that the reset PC also points at.
package ysyx_22040127_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] MEM_BASE = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040127_mem_responder_if.sv
// Request/response channel between the core's memory stage (master) and the
// memory responder (slave).
interface ysyx_22040127_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22040127_dword_ram.sv
// Single-port doubleword storage: byte-masked synchronous write and a registered
// read that holds its value until the next read enable. Contents are not reset.
module ysyx_22040127_dword_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [63:0]           i_wdata,
  input  logic [7:0]            i_wmask,
  output logic [63:0]           o_rdata
);

  logic [63:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wmask[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_22040127_mem_responder.sv
// Latency-bearing memory responder: accepts one request at a time, serves it
// from local storage and returns the result LATENCY cycles after acceptance.
module ysyx_22040127_mem_responder
  import ysyx_22040127_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE  = MEM_BASE,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_22040127_mem_responder_if.slave bus
);

  localparam logic [63:0] SPAN   = 64'd8 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic        r_write;
  logic        r_err;

  logic [63:0]           w_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [63:0]           w_ram_rdata;
  logic                  w_rsp_valid;

  // Modulo-2^64 offset: addresses below the base wrap high and fail the check.
  assign w_off      = bus.req_addr - ADDR_BASE;
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = w_off[DEPTH_LOG2+2:3];

  assign w_req_ready = rst & (r_state == IDLE);
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_ram_we    = w_accept & bus.req_write & w_in_range;
  assign w_ram_re    = w_accept & ~bus.req_write & w_in_range;

  ysyx_22040127_dword_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_idx  (w_idx),
    .i_wdata(bus.req_wdata),
    .i_wmask(bus.req_wmask),
    .o_rdata(w_ram_rdata)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY <= 1) begin
            w_state_nx = RESP;
            w_cnt_nx   = 4'd0;
          end else begin
            w_state_nx = BUSY;
            w_cnt_nx   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (r_cnt <= 4'd1) begin
          w_state_nx = RESP;
          w_cnt_nx   = 4'd0;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_err   <= ~w_in_range;
      end
    end
  end

  // Read data only surfaces for a successful load; the RAM output is unreset.
  assign w_rsp_valid   = (r_state == RESP);
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_err   = w_rsp_valid & r_err;
  assign bus.rsp_rdata = (w_rsp_valid & ~r_write & ~r_err) ? w_ram_rdata : 64'd0;

endmodule

// File: tb/tb_ysyx_22040127_mem_responder.sv
// Bench for the memory responder: directed scenarios plus randomized traffic
// scored against a word-addressed reference memory.
module tb_ysyx_22040127_mem_responder;
  import ysyx_22040127_pkg::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned DL2  = 10;
  localparam logic [63:0] BASE = MEM_BASE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040127_mem_responder_if bus();

  ysyx_22040127_mem_responder #(
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(DL2),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] model [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'h2000);
  endfunction

  task automatic model_exp(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, output logic [63:0] er, output logic ee);
    logic [63:0] key;
    logic [63:0] w;
    key = {addr[63:3], 3'b000};
    er  = 64'd0;
    ee  = 1'b0;
    if (!in_rng(addr)) begin
      ee = 1'b1;
    end else if (wr) begin
      w = model.exists(key) ? model[key] : 64'd0;
      for (int b = 0; b < 8; b++) if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[key] = w;
    end else begin
      er = model[key];
    end
  endtask

  task automatic drive_req(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
  endtask

  task automatic scramble_req();
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    bus.req_wmask = 8'($urandom);
  endtask

  // Called just after a falling edge; returns on a falling edge.
  task automatic xact(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask, input int hold, input string tag,
                      output logic [63:0] obs);
    logic [63:0] er;
    logic        ee;
    int          n;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".rdy"}, 64'(bus.req_ready), 64'd1);
    model_exp(wr, addr, wdata, wmask, er, ee);
    drive_req(wr, addr, wdata, wmask);
    @(negedge clk);
    scramble_req();
    n = 1;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, ".lat"}, 64'(n), 64'(LAT));
    chk({tag, ".err"}, 64'(bus.rsp_err), 64'(ee));
    chk({tag, ".rdata"}, bus.rsp_rdata, er);
    chk({tag, ".rdy_busy"}, 64'(bus.req_ready), 64'd0);
    obs = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_vld"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, er);
      chk({tag, ".hold_err"}, 64'(bus.rsp_err), 64'(ee));
      chk({tag, ".hold_rdy"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, ".post_vld"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".post_rdy"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Accept a request, then pull reset one cycle later.
  task automatic xact_rst(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, input string tag);
    logic [63:0] er;
    logic        ee;
    chk({tag, ".rdy"}, 64'(bus.req_ready), 64'd1);
    model_exp(wr, addr, wdata, wmask, er, ee);
    drive_req(wr, addr, wdata, wmask);
    @(negedge clk);
    scramble_req();
    rst = 1'b0;
    #1;
    chk({tag, ".rst_vld"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".rst_rdy"}, 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, ".rst_vld"}, 64'(bus.rsp_valid), 64'd0);
    end
    rst = 1'b1;
    #1;
    chk({tag, ".rel_rdy"}, 64'(bus.req_ready), 64'd1);
    for (int i = 0; i <= int'(LAT); i++) begin
      @(negedge clk);
      chk({tag, ".rel_vld"}, 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [63:0] obs;
    logic [63:0] a;
    logic [63:0] d;
    bit          wr;
    int          sel;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_wmask = 8'd0;
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset.rdy", 64'(bus.req_ready), 64'd0);
      chk("reset.vld", 64'(bus.rsp_valid), 64'd0);
    end
    rst = 1'b1;
    #1;
    chk("release.rdy", 64'(bus.req_ready), 64'd1);
    chk("release.vld", 64'(bus.rsp_valid), 64'd0);
    chk("release.rdata", bus.rsp_rdata, 64'd0);
    chk("release.err", 64'(bus.rsp_err), 64'd0);

    xact(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, "wr_full", obs);
    xact(1'b0, 64'h8000_0014, 64'd0, 8'h00, 0, "rd_full", obs);
    chk("rd_full.const", obs, 64'h1122_3344_5566_7788);

    xact(1'b1, 64'h8000_0010, 64'h0000_0000_AB00_0000, 8'b0000_1000, 0, "wr_part", obs);
    xact(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, "rd_part", obs);
    chk("rd_part.const", obs, 64'h1122_3344_AB66_7788);

    xact(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, "wr_nomask", obs);
    xact(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5, "bp_read", obs);

    xact(1'b1, BASE, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, "wr_w0", obs);
    xact(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, "oor_rd", obs);
    xact(1'b1, BASE + 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "oor_wr", obs);
    xact(1'b0, BASE, 64'd0, 8'h00, 0, "rd_w0", obs);
    chk("rd_w0.const", obs, 64'hDEAD_BEEF_0BAD_F00D);

    xact_rst(1'b0, 64'h8000_0010, 64'd0, 8'h00, "rst_rd");
    xact_rst(1'b1, 64'h8000_0030, 64'hCAFE_F00D_1234_5678, 8'hF0, "rst_wr");
    xact(1'b1, 64'h8000_0038, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, "wr_after", obs);

    for (int k = 0; k < 8; k++) begin
      xact(1'b1, BASE + 64'h100 + 64'(8 * k), {$urandom, $urandom}, 8'hFF, 0, "init", obs);
    end
    xact(1'b0, 64'h8000_0030, 64'd0, 8'h00, 0, "rd_rstwr", obs);
    chk("rd_rstwr.const", obs[63:32], 64'hCAFE_F00D);

    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom);
      d   = {$urandom, $urandom};
      if (sel == 0) a = BASE - 64'(8 * $urandom_range(1, 64));
      else if (sel == 1) a = BASE + 64'h2000 + 64'($urandom_range(0, 4095));
      else if (sel == 2) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else a = BASE + 64'h100 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
      xact(wr, a, d, 8'($urandom), int'($urandom_range(0, 3)), "rand", obs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
